// File: rtl/gamepad_pkg.sv
// Shared definitions for the multi-pad Genesis controller scanner:
// button bit positions, pin positions within a pad slice, scan phases.
package gamepad_pkg;

  // Bit positions within a pad's 12-bit button word (active-high).
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;
  localparam int NUM_BUTTONS = 12;

  // Connector pin positions within a pad's 6-bit pin slice.
  localparam int PIN_1 = 0;
  localparam int PIN_2 = 1;
  localparam int PIN_3 = 2;
  localparam int PIN_4 = 3;
  localparam int PIN_6 = 4;
  localparam int PIN_9 = 5;
  localparam int PINS_PER_PAD = 6;

  // Scan sequence: idle between frames, then eight equal-length phases.
  typedef enum logic [3:0] {
    IDLE,
    PH0,
    PH1,
    PH2,
    PH3,
    PH4,
    PH5,
    PH6,
    PH7
  } phase_t;

  // Odd phases pull Select low on enabled pads; everything else leaves it high.
  function automatic logic select_low_phase(input phase_t ph);
    return (ph == PH1) || (ph == PH3) || (ph == PH5) || (ph == PH7);
  endfunction

endpackage

// File: rtl/gamepad_pad_decoder.sv
// Per-pad logic: enable latch, Select drive, shadow sampling of the pins
// during the scan, and the masked atomic publish with press-event pulses.
module gamepad_pad_decoder
  import gamepad_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pad_enable,
  input  logic [PINS_PER_PAD-1:0] pins,
  input  phase_t                  state,
  input  phase_t                  next_state,
  input  logic                    phase_last,
  input  logic                    publish,
  output logic                    select,
  output logic [NUM_BUTTONS-1:0]  saidas,
  output logic [NUM_BUTTONS-1:0]  pressed,
  output logic                    six_button,
  output logic                    connected
);

  logic                   enable_q;
  logic [NUM_BUTTONS-1:0] shadow_buttons;
  logic                   shadow_six;
  logic                   shadow_conn;
  logic [NUM_BUTTONS-1:0] masked_buttons;
  logic                   pub_conn;
  logic                   pub_six;

  // Enable is captured once per scan so mid-scan changes wait for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
    end else if (start) begin
      enable_q <= pad_enable;
    end
  end

  // Select follows the phase being entered, so it changes on a phase's first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      select <= 1'b1;
    end else begin
      select <= !(enable_q && select_low_phase(next_state));
    end
  end

  // Pins are sampled on the last cycle of a phase, after the full settle time.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_buttons <= '0;
      shadow_six     <= 1'b0;
      shadow_conn    <= 1'b0;
    end else if (phase_last) begin
      case (state)
        PH1: begin
          shadow_buttons[BTN_A]     <= !pins[PIN_6];
          shadow_buttons[BTN_START] <= !pins[PIN_9];
          shadow_conn               <= !pins[PIN_3] && !pins[PIN_4];
        end
        PH2: begin
          shadow_buttons[BTN_UP]    <= !pins[PIN_1];
          shadow_buttons[BTN_DOWN]  <= !pins[PIN_2];
          shadow_buttons[BTN_LEFT]  <= !pins[PIN_3];
          shadow_buttons[BTN_RIGHT] <= !pins[PIN_4];
          shadow_buttons[BTN_B]     <= !pins[PIN_6];
          shadow_buttons[BTN_C]     <= !pins[PIN_9];
        end
        PH5: begin
          shadow_six <= !pins[PIN_1] && !pins[PIN_2] && !pins[PIN_3] && !pins[PIN_4];
        end
        PH6: begin
          shadow_buttons[BTN_Z]    <= !pins[PIN_1];
          shadow_buttons[BTN_Y]    <= !pins[PIN_2];
          shadow_buttons[BTN_X]    <= !pins[PIN_3];
          shadow_buttons[BTN_MODE] <= !pins[PIN_4];
        end
        default: begin
        end
      endcase
    end
  end

  // Hide extended buttons on 3-button pads and everything on absent or disabled pads.
  always_comb begin
    masked_buttons = shadow_buttons;
    if (!shadow_six) begin
      masked_buttons[BTN_X]    = 1'b0;
      masked_buttons[BTN_Y]    = 1'b0;
      masked_buttons[BTN_Z]    = 1'b0;
      masked_buttons[BTN_MODE] = 1'b0;
    end
    if (!shadow_conn || !enable_q) begin
      masked_buttons = '0;
    end
  end

  assign pub_conn = shadow_conn && enable_q;
  assign pub_six  = shadow_six && pub_conn;

  // All visible outputs update together on publish; press pulses last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      saidas     <= '0;
      pressed    <= '0;
      six_button <= 1'b0;
      connected  <= 1'b0;
    end else begin
      pressed <= '0;
      if (publish) begin
        saidas     <= masked_buttons;
        pressed    <= masked_buttons & ~saidas;
        six_button <= pub_six;
        connected  <= pub_conn;
      end
    end
  end

endmodule

// File: rtl/gamepad_multi_scanner.sv
// Frame-triggered scanner for several Genesis pads: synchronises v_sync,
// sequences the eight read phases and fans the phase out to per-pad decoders.
module gamepad_multi_scanner
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int PHASE_CYCLES = 1000
) (
  input  logic                             Clock50,
  input  logic                             Reset,
  input  logic                             v_sync,
  input  logic [NUM_PADS-1:0]              Pad_Enable,
  input  logic [PINS_PER_PAD*NUM_PADS-1:0] Pad_Pins,
  output logic [NUM_PADS-1:0]              Select,
  output logic [NUM_BUTTONS*NUM_PADS-1:0]  Saidas,
  output logic [NUM_BUTTONS*NUM_PADS-1:0]  Pressed,
  output logic [NUM_PADS-1:0]              Six_Button,
  output logic [NUM_PADS-1:0]              Connected,
  output logic                             Frame_Done
);

  localparam int CNT_W = $clog2(PHASE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PHASE_CYCLES - 1);

  logic             vsync_meta;
  logic             vsync_sync;
  logic             fall_q;
  phase_t           state;
  phase_t           next_state;
  logic [CNT_W-1:0] phase_count;
  logic             phase_last;
  logic             start;
  logic             publish;

  // Two-flop synchroniser plus a registered falling-edge strobe.
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      vsync_meta <= 1'b0;
      vsync_sync <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      vsync_meta <= v_sync;
      vsync_sync <= vsync_meta;
      fall_q     <= !vsync_meta && vsync_sync;
    end
  end

  assign phase_last = (state != IDLE) && (phase_count == LAST_COUNT);
  assign start      = (state == IDLE) && fall_q;
  assign publish    = (state == PH7) && phase_last;

  // Phase register and per-phase cycle counter, which restarts at every boundary.
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      state       <= IDLE;
      phase_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE || phase_last) begin
        phase_count <= '0;
      end else begin
        phase_count <= phase_count + CNT_W'(1);
      end
    end
  end

  // Next phase: falls outside IDLE are ignored, PH7 returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fall_q) begin
          next_state = PH0;
        end
      end
      PH7: begin
        if (phase_last) begin
          next_state = IDLE;
        end
      end
      default: begin
        if (phase_last) begin
          next_state = phase_t'(state + 4'd1);
        end
      end
    endcase
  end

  // Frame_Done marks the single cycle on which the decoders' outputs change.
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      Frame_Done <= 1'b0;
    end else begin
      Frame_Done <= publish;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    gamepad_pad_decoder u_decoder (
      .clk        (Clock50),
      .reset      (Reset),
      .start      (start),
      .pad_enable (Pad_Enable[p]),
      .pins       (Pad_Pins[PINS_PER_PAD*p +: PINS_PER_PAD]),
      .state      (state),
      .next_state (next_state),
      .phase_last (phase_last),
      .publish    (publish),
      .select     (Select[p]),
      .saidas     (Saidas[NUM_BUTTONS*p +: NUM_BUTTONS]),
      .pressed    (Pressed[NUM_BUTTONS*p +: NUM_BUTTONS]),
      .six_button (Six_Button[p]),
      .connected  (Connected[p])
    );
  end

endmodule

// File: tb/tb_gamepad_multi_scanner.sv
// Bench for gamepad_multi_scanner: behavioural Genesis pads answer the
// Select line, and the expected published words come from the pad contents.
module tb_gamepad_multi_scanner;
  localparam int NUM_PADS     = 2;
  localparam int PHASE_CYCLES = 8;
  localparam int SCAN_LATENCY = 8 * PHASE_CYCLES + 3;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_A = 4, B_B = 5;
  localparam int B_C = 6, B_X = 7, B_Y = 8, B_Z = 9, B_START = 10, B_MODE = 11;
  localparam logic [11:0] THREE_BUTTON_MASK = 12'h47F;

  logic                    Clock50 = 1'b0;
  logic                    Reset = 1'b1;
  logic                    v_sync = 1'b1;
  logic [NUM_PADS-1:0]     Pad_Enable = '1;
  logic [6*NUM_PADS-1:0]   Pad_Pins;
  logic [NUM_PADS-1:0]     Select;
  logic [12*NUM_PADS-1:0]  Saidas;
  logic [12*NUM_PADS-1:0]  Pressed;
  logic [NUM_PADS-1:0]     Six_Button;
  logic [NUM_PADS-1:0]     Connected;
  logic                    Frame_Done;

  logic [11:0] pad_buttons [NUM_PADS];
  bit          pad_six     [NUM_PADS];
  bit          pad_present [NUM_PADS];
  int          lows        [NUM_PADS] = '{default: 0};
  int          high_run    [NUM_PADS] = '{default: 0};
  logic        prev_sel    [NUM_PADS] = '{default: 1'b1};
  logic [11:0] exp_saidas  [NUM_PADS] = '{default: 12'h000};

  int assertions = 0;
  int failures   = 0;

  gamepad_multi_scanner #(
    .NUM_PADS     (NUM_PADS),
    .PHASE_CYCLES (PHASE_CYCLES)
  ) dut (
    .Clock50    (Clock50),
    .Reset      (Reset),
    .v_sync     (v_sync),
    .Pad_Enable (Pad_Enable),
    .Pad_Pins   (Pad_Pins),
    .Select     (Select),
    .Saidas     (Saidas),
    .Pressed    (Pressed),
    .Six_Button (Six_Button),
    .Connected  (Connected),
    .Frame_Done (Frame_Done)
  );

  always #5 Clock50 = ~Clock50;

  // Genesis pad behaviour: the pin set depends on Select and how many times it went low.
  function automatic logic [5:0] pad_pins(input logic [11:0] b, input bit six,
                                          input bit present, input logic sel, input int nlow);
    if (!present) return 6'h3F;
    if (sel) begin
      if (six && nlow == 3) return ~{b[B_C], b[B_B], b[B_MODE], b[B_X], b[B_Y], b[B_Z]};
      return ~{b[B_C], b[B_B], b[B_RIGHT], b[B_LEFT], b[B_DOWN], b[B_UP]};
    end
    if (six && nlow == 3) return ~{b[B_START], b[B_A], 4'b1111};
    return ~{b[B_START], b[B_A], 1'b1, 1'b1, b[B_DOWN], b[B_UP]};
  endfunction

  // Expected published word from what the player is holding.
  function automatic logic [11:0] exp_word(input logic [11:0] b, input bit six,
                                           input bit present, input logic en);
    if (!present || !en) return 12'h000;
    if (!six) return b & THREE_BUTTON_MASK;
    return b;
  endfunction

  function automatic logic [11:0] rand_buttons();
    logic [11:0] b;
    b = 12'($urandom_range(0, 4095));
    if (b[B_UP] && b[B_DOWN]) b[B_DOWN] = 1'b0;
    return b;
  endfunction

  always_comb begin
    Pad_Pins = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      Pad_Pins[6*p +: 6] = pad_pins(pad_buttons[p], pad_six[p], pad_present[p], Select[p], lows[p]);
    end
  end

  // Pad counter of Select lows; a long high period resets the pad's sequence.
  always @(posedge Clock50) begin
    for (int p = 0; p < NUM_PADS; p++) begin
      prev_sel[p] <= Select[p];
      if (Select[p]) begin
        high_run[p] <= high_run[p] + 1;
        if (high_run[p] >= PHASE_CYCLES) lows[p] <= 0;
      end else begin
        high_run[p] <= 0;
        if (prev_sel[p]) lows[p] <= lows[p] + 1;
      end
    end
  end

  task automatic applyStimulus(input int p, input logic [11:0] b, input bit six, input bit present);
    pad_buttons[p] = b;
    pad_six[p]     = six;
    pad_present[p] = present;
  endtask

  // One complete frame: fall on v_sync, wait for Frame_Done, compare against the model.
  task automatic run_scan(input bit aligned, input bit check_after, input int inject_at,
                          input int en_change_at, input logic [NUM_PADS-1:0] en_new, input string tag);
    logic [NUM_PADS-1:0] en_lat;
    logic [11:0] new_word [NUM_PADS];
    int low_cycles [NUM_PADS];
    int n;
    bit seen;
    bit stable_ok;
    en_lat = Pad_Enable;
    for (int p = 0; p < NUM_PADS; p++) begin
      new_word[p]   = exp_word(pad_buttons[p], pad_six[p], pad_present[p], en_lat[p]);
      low_cycles[p] = 0;
    end
    if (!aligned) @(negedge Clock50);
    v_sync = 1'b0;
    n = 0;
    seen = 1'b0;
    stable_ok = 1'b1;
    while (!seen && n < SCAN_LATENCY + 40) begin
      @(posedge Clock50);
      #1;
      n++;
      if (n == 5) v_sync = 1'b1;
      if (inject_at > 0 && n == inject_at) v_sync = 1'b0;
      if (inject_at > 0 && n == inject_at + 3) v_sync = 1'b1;
      if (n == en_change_at) Pad_Enable = en_new;
      for (int p = 0; p < NUM_PADS; p++) if (Select[p] === 1'b0) low_cycles[p]++;
      if (Frame_Done === 1'b1) seen = 1'b1;
      else for (int p = 0; p < NUM_PADS; p++) if (Saidas[12*p +: 12] !== exp_saidas[p]) stable_ok = 1'b0;
    end
    assertions++;
    if (!stable_ok) begin
      failures++;
      $display("[TB] FAIL %s outputs_stable: Saidas changed before Frame_Done", tag);
    end
    assertions++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s frame_done_timeout: no Frame_Done within %0d cycles", tag, n);
    end else begin
      assertions++;
      if (n != SCAN_LATENCY) begin
        failures++;
        $display("[TB] FAIL %s latency: got %0d expected %0d", tag, n, SCAN_LATENCY);
      end
      for (int p = 0; p < NUM_PADS; p++) begin
        assertions += 5;
        if (Saidas[12*p +: 12] !== new_word[p]) begin
          failures++;
          $display("[TB] FAIL %s saidas pad%0d: got %h expected %h", tag, p, Saidas[12*p +: 12], new_word[p]);
        end
        if (Pressed[12*p +: 12] !== (new_word[p] & ~exp_saidas[p])) begin
          failures++;
          $display("[TB] FAIL %s pressed pad%0d: got %h expected %h", tag, p, Pressed[12*p +: 12],
                   new_word[p] & ~exp_saidas[p]);
        end
        if (Six_Button[p] !== (en_lat[p] && pad_present[p] && pad_six[p])) begin
          failures++;
          $display("[TB] FAIL %s six_button pad%0d: got %b expected %b", tag, p, Six_Button[p],
                   en_lat[p] && pad_present[p] && pad_six[p]);
        end
        if (Connected[p] !== (en_lat[p] && pad_present[p])) begin
          failures++;
          $display("[TB] FAIL %s connected pad%0d: got %b expected %b", tag, p, Connected[p],
                   en_lat[p] && pad_present[p]);
        end
        if (low_cycles[p] != (en_lat[p] ? 4 * PHASE_CYCLES : 0)) begin
          failures++;
          $display("[TB] FAIL %s select_low_cycles pad%0d: got %0d expected %0d", tag, p, low_cycles[p],
                   en_lat[p] ? 4 * PHASE_CYCLES : 0);
        end
        exp_saidas[p] = new_word[p];
      end
    end
    if (check_after) begin
      @(posedge Clock50);
      #1;
      assertions += 2;
      if (Frame_Done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s frame_done_width: got %b expected 0", tag, Frame_Done);
      end
      if (Pressed !== '0) begin
        failures++;
        $display("[TB] FAIL %s pressed_width: got %h expected 0", tag, Pressed);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock50);
    #1;
    assertions += 5;
    if (Select !== '1) begin failures++; $display("[TB] FAIL reset select: got %b expected all 1", Select); end
    if (Saidas !== '0) begin failures++; $display("[TB] FAIL reset saidas: got %h expected 0", Saidas); end
    if (Pressed !== '0) begin failures++; $display("[TB] FAIL reset pressed: got %h expected 0", Pressed); end
    if ({Six_Button, Connected} !== '0) begin
      failures++;
      $display("[TB] FAIL reset status: got %b expected 0", {Six_Button, Connected});
    end
    if (Frame_Done !== 1'b0) begin failures++; $display("[TB] FAIL reset frame_done: got %b expected 0", Frame_Done); end
    @(negedge Clock50);
    Reset = 1'b0;
    repeat (5) @(posedge Clock50);
  endtask

  task automatic test_six_button();
    applyStimulus(0, 12'h210, 1'b1, 1'b1);
    applyStimulus(1, rand_buttons(), 1'b1, 1'b1);
    run_scan(1'b0, 1'b1, 0, 0, '0, "six_button");
  endtask

  task automatic test_three_button();
    applyStimulus(0, 12'h408 | 12'h380, 1'b0, 1'b1);
    applyStimulus(1, rand_buttons(), 1'b0, 1'b1);
    run_scan(1'b0, 1'b1, 0, 0, '0, "three_button");
  endtask

  task automatic test_absent_pad();
    applyStimulus(0, rand_buttons(), 1'b1, 1'b1);
    applyStimulus(1, 12'hFFF, 1'b1, 1'b0);
    run_scan(1'b0, 1'b1, 0, 0, '0, "absent_pad");
  endtask

  task automatic test_enable();
    applyStimulus(0, rand_buttons(), 1'b1, 1'b1);
    applyStimulus(1, 12'h0F1, 1'b1, 1'b1);
    Pad_Enable = 2'b11;
    run_scan(1'b0, 1'b1, 0, 20, 2'b01, "enable_latched");
    run_scan(1'b0, 1'b1, 0, 0, '0, "enable_off");
    Pad_Enable = 2'b11;
  endtask

  task automatic test_vsync_ignored();
    int extra;
    applyStimulus(0, 12'h210, 1'b1, 1'b1);
    applyStimulus(1, 12'h00C, 1'b0, 1'b1);
    run_scan(1'b0, 1'b1, 37, 0, '0, "vsync_in_ph4");
    extra = 0;
    repeat (100) begin
      @(posedge Clock50);
      #1;
      if (Frame_Done === 1'b1) extra++;
    end
    assertions++;
    if (extra != 0) begin failures++; $display("[TB] FAIL extra_frame_done: got %0d expected 0", extra); end
    run_scan(1'b0, 1'b1, 0, 0, '0, "held_second_frame");
  endtask

  task automatic test_reset_mid_ph3();
    int dones;
    applyStimulus(0, 12'h0A5, 1'b1, 1'b1);
    applyStimulus(1, 12'h012, 1'b0, 1'b1);
    @(negedge Clock50);
    v_sync = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge Clock50);
      #1;
      if (n == 5) v_sync = 1'b1;
    end
    Reset = 1'b1;
    @(posedge Clock50);
    #1;
    assertions += 3;
    if (Select !== '1) begin failures++; $display("[TB] FAIL midreset select: got %b expected all 1", Select); end
    if (Saidas !== '0) begin failures++; $display("[TB] FAIL midreset saidas: got %h expected 0", Saidas); end
    if (Frame_Done !== 1'b0) begin failures++; $display("[TB] FAIL midreset frame_done: got %b expected 0", Frame_Done); end
    Reset = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) exp_saidas[p] = 12'h000;
    dones = 0;
    repeat (100) begin
      @(posedge Clock50);
      #1;
      if (Frame_Done === 1'b1) dones++;
    end
    assertions++;
    if (dones != 0) begin failures++; $display("[TB] FAIL aborted_scan_frame_done: got %0d expected 0", dones); end
    run_scan(1'b0, 1'b1, 0, 0, '0, "after_midreset");
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, rand_buttons(), 1'b1, 1'b1);
    applyStimulus(1, rand_buttons(), 1'b0, 1'b1);
    run_scan(1'b0, 1'b0, 0, 0, '0, "b2b_first");
    applyStimulus(0, rand_buttons(), 1'b0, 1'b1);
    applyStimulus(1, rand_buttons(), 1'b1, 1'b1);
    run_scan(1'b1, 1'b1, 0, 0, '0, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        applyStimulus(p, rand_buttons(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      Pad_Enable = NUM_PADS'($urandom_range(0, (1 << NUM_PADS) - 1));
      run_scan(1'b0, 1'b1, 0, 0, '0, "random");
      repeat ($urandom_range(0, 20)) @(posedge Clock50);
    end
    Pad_Enable = '1;
  endtask

  initial begin
    for (int p = 0; p < NUM_PADS; p++) applyStimulus(p, 12'h000, 1'b0, 1'b1);
    $display("[TB] gamepad_multi_scanner bench start");
    test_reset();
    test_six_button();
    test_three_button();
    test_absent_pad();
    test_enable();
    test_vsync_ignored();
    test_reset_mid_ph3();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/gamepad_multi_scanner.md
# gamepad_multi_scanner

Parametrised multi-pad Genesis-style controller scanner: drives a Select line per pad through an 8-phase read sequence triggered once per video frame by the falling edge of v_sync. It decodes 3- and 6-button pads with automatic type detection, and reports connection status. It publishes button state atomically once per frame, with one-cycle press-event pulses. It replaces the single-pad reader between the pad connector pins and the game logic.

## Interface
- NUM_PADS, 2, number of independent pad connectors scanned in parallel (1..4)
- PHASE_CYCLES, 1000, Clock50 cycles per scan phase (≥4); counter width = clog2(PHASE_CYCLES)
- Clock50  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- v_sync  in  1  asynchronous frame sync; falling edge starts a scan
- Pad_Enable  in  NUM_PADS  per-pad enable, latched at scan start
- Pad_Pins  in  6*NUM_PADS  per pad p, slice [6p+5:6p] = {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}, active-low buttons
- Select  out  NUM_PADS  per-pad select line
- Saidas  out  12*NUM_PADS  per pad, active-high {Mode, Start, Z, Y, X, C, B, A, Right, Left, Down, Up} (bit 11..0)
- Pressed  out  12*NUM_PADS  one-cycle pulse per button on a 0→1 transition of Saidas
- Six_Button  out  NUM_PADS  pad identified as 6-button in last scan
- Connected  out  NUM_PADS  pad detected present in last scan
- Frame_Done  out  1  one-cycle pulse when outputs update

## Operation
- v_sync passes through a two-flop synchroniser; fall detected when flop1=0 and flop2=1.
- FSM states: IDLE, PH0..PH7. IDLE→PH0 on detected fall. Each PHn lasts exactly PHASE_CYCLES cycles, then goes to PHn+1. PH7 goes to IDLE.
- Select[p] = 0 in PH1, PH3, PH5 and PH7 when the latched enable bit is 1. Otherwise Select[p] = 1, including in IDLE and for disabled pads.
- Each phase samples the pins on its last cycle (counter = PHASE_CYCLES-1) into a shadow register:
  - PH1: A←!Pino6, Start←!Pino9; connected ← (Pino3=0 && Pino4=0).
  - PH2: Up, Down, Left, Right ← !Pino1..!Pino4; B←!Pino6, C←!Pino9.
  - PH5: six-button ← (Pino1..Pino4 all 0).
  - PH6: Z←!Pino1, Y←!Pino2, X←!Pino3, Mode←!Pino4.
- Publishing happens at the end of PH7, one cycle after leaving PH7:
  - Shadow state is copied to Saidas, Six_Button and Connected.
  - Frame_Done=1 for that one cycle.
  - Pressed = new & ~old for that one cycle only.
- Masking at publish:
  - Six_Button=0: X, Y, Z and Mode are forced to 0.
  - Connected=0 or pad disabled: all 12 bits, Six_Button and Connected are forced to 0.
- A v_sync fall while not in IDLE is ignored; there is no queueing.

## Timing
- Reset (any state, incl. mid-scan) sets:
  - state to IDLE, counter to 0, shadow registers to 0;
  - Select all 1s; Saidas, Pressed, Six_Button, Connected all 0; Frame_Done 0.
- An aborted scan never produces Frame_Done.
- v_sync fall to entry into PH0: 3 cycles. Scan length: exactly 8*PHASE_CYCLES cycles. Frame_Done occurs at 8*PHASE_CYCLES+3 cycles after the fall.
- Select is registered and changes on the first cycle of a phase. There are PHASE_CYCLES-1 cycles of settle time before each sample.
- Outputs are stable between Frame_Done pulses. No partial updates are visible.
- Phase counter wraps to 0 at every phase boundary. A v_sync fall on the Frame_Done cycle is detected; the next scan starts normally.
- Pad_Enable changes mid-scan take effect at the next scan.

## Structure
- Package gamepad_pkg holds:
  - button bit indices (UP=0 … MODE=11);
  - pin indices within a pad slice;
  - the phase-state enum {IDLE, PH0..PH7} and the phase-to-Select map.
- Top level holds the synchroniser, FSM, phase counter and Frame_Done.
- Sub-module gamepad_pad_decoder, instantiated NUM_PADS times, holds the per-pad enable latch, Select, shadow sampling, masking, publish and Pressed logic.

## Test plan
- **Reset mid-PH3:** assert Reset during PH3 → next cycle Select all 1s, Saidas=0, no Frame_Done; the next v_sync fall runs a full scan.
- **6-button pad, PHASE_CYCLES=8, pad0 A+Z pressed:** Frame_Done at cycle 67 after the fall. Saidas[11:0]=12'h210, Six_Button[0]=1, Connected[0]=1, Pressed=12'h210 for one cycle.
- **3-button pad model (PH5 pins stay high), Start+Right held:** Saidas=12'h408 and Six_Button=0, even if the PH6 pins are low.
- **Pad1 absent (all pins pulled high):** Connected[1]=0 and Saidas[23:12]=0. Pad0 is decoded independently in the same scan.
- **Pad_Enable=2'b01:** Select[1] stays 1 for the whole scan; pad1 outputs are 0.
- **Second v_sync fall injected in PH4:** ignored; exactly one Frame_Done. With a button held across two frames, Pressed pulses only in the first frame.
